wb_ctrl: RTL

- Writeback controller: the write-side producer for the 16-entry register file's single write port (wbEn/wbIdx/wbData).
- Collects results from the ALU and the load unit through valid/ready, queues them in a small FIFO, and drains one per granted cycle.
- Index 15 is the PC: a result for index 15 is redirected to the PC write outputs and never reaches the register file.
- Keeps a pending-destination scoreboard so decode can stall on RAW hazards.

---
 rtl/wb_pkg.sv | 36 +++
 rtl/wb_fifo.sv | 82 ++++++++
 rtl/wb_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
//   Shared definitions for the writeback controller slice.
//
//   DW / AW / DEPTH : default data width, register index width, FIFO depth
//   NREGS           : number of architectural registers (width of pendMask)
//   PC_IDX          : register index that aliases the program counter
//   wb_entry_t      : one queued result {idx, data}
//   wb_src_e        : which producer won the enqueue slot this cycle
//   is_pc()         : true when an index addresses the PC
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 4;
    localparam int NREGS = 16;

    localparam logic [3:0] PC_IDX = 4'd15;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_LD   = 2'd1,
        SRC_ALU  = 2'd2
    } wb_src_e;

    function automatic logic is_pc(input logic [AW-1:0] idx);
        return idx == PC_IDX;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
//   Parameterised synchronous FIFO holding pending writeback results.
//   Push and pop may occur in the same cycle; pointers wrap modulo DEPTH,
//   so DEPTH must be a power of two (>= 2).
//
//   Parameters
//     DEPTH : number of entries
//     W     : entry width in bits
//
//   Ports
//     clk    in   clock, all state on the rising edge
//     rst_n  in   asynchronous active-low reset (clears pointers and count)
//     push   in   write din at the tail (ignored while full)
//     pop    in   advance the head (ignored while empty)
//     din    in   entry to enqueue
//     dout   out  entry at the head (meaningless while empty)
//     full   out  count == DEPTH
//     empty  out  count == 0
//     count  out  number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: the storage array has no reset; occupancy is tracked by count, so
    // stale contents are never observed and the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_ctrl.sv
// -----------------------------------------------------------------------------
// wb_ctrl
//   Writeback controller: sole producer for the register file's write port.
//   Accepts results from the load unit and the ALU (load has priority), queues
//   them in wb_fifo and drains one per cycle in which the write port is granted.
//   A result addressed to PC_IDX is steered to the PC write outputs instead of
//   the register file. A pending-destination mask lets decode stall on RAW
//   hazards.
//
//   Build option
//     WB_BYPASS_EN : when defined, a result arriving while the FIFO is empty
//                    and the write port is granted is written in the same
//                    cycle without being queued. When undefined every result
//                    is queued and appears no earlier than the next cycle.
//
//   Ports
//     clk, rst_n          clock / asynchronous active-low reset
//     allocEn, allocIdx   decode marks allocIdx as having an outstanding producer
//     aluValid/Idx/Data   ALU result handshake input, aluReady = accepted
//     ldValid/Idx/Data    load result handshake input, ldReady = accepted
//     wbGnt               register-file write port available this cycle
//     wbEn/wbIdx/wbData   register-file write (index != PC_IDX)
//     pcWrEn/pcWrData     PC write (index == PC_IDX)
//     pendMask            bit i set while register i has an outstanding producer
//     full, empty         FIFO occupancy flags
//   wbIdx/wbData/pcWrData read as zero whenever their enable is low.
// -----------------------------------------------------------------------------
module wb_ctrl
    import wb_pkg::*;
#(
    parameter int DEPTH = wb_pkg::DEPTH,
    parameter int DW    = wb_pkg::DW,
    parameter int AW    = wb_pkg::AW
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             allocEn,
    input  logic [AW-1:0]    allocIdx,

    input  logic             aluValid,
    input  logic [AW-1:0]    aluIdx,
    input  logic [DW-1:0]    aluData,
    output logic             aluReady,

    input  logic             ldValid,
    input  logic [AW-1:0]    ldIdx,
    input  logic [DW-1:0]    ldData,
    output logic             ldReady,

    input  logic             wbGnt,
    output logic             wbEn,
    output logic [AW-1:0]    wbIdx,
    output logic [DW-1:0]    wbData,

    output logic             pcWrEn,
    output logic [DW-1:0]    pcWrData,

    output logic [NREGS-1:0] pendMask,
    output logic             full,
    output logic             empty
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } entry_t;

    wb_src_e          src;
    entry_t           in_entry;
    entry_t           head_entry;
    entry_t           out_entry;
    logic [AW+DW-1:0] fifo_dout;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             room;
    logic             in_fire;
    logic             push;
    logic             pop;
    logic             bypass;
    logic             out_valid;
    logic             out_is_pc;
    logic [NREGS-1:0] pend_next;

    // ------------------------------------------------------------------
    // Enqueue arbitration. Readiness depends only on occupancy: a pop in
    // the same cycle does not free a slot for a new arrival.
    // ------------------------------------------------------------------
    assign room     = (fifo_count != CW'(DEPTH));
    assign ldReady  = room;
    assign aluReady = room && !ldValid;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        src      = SRC_NONE;
        in_entry = '0;
        if (ldValid && ldReady) begin
            src      = SRC_LD;
            in_entry = '{idx: ldIdx, data: ldData};
        end else if (aluValid && aluReady) begin
            src      = SRC_ALU;
            in_entry = '{idx: aluIdx, data: aluData};
        end
    end

    assign in_fire = (src != SRC_NONE);

    // ------------------------------------------------------------------
    // Dequeue and optional same-cycle bypass.
    // ------------------------------------------------------------------
    assign pop = !fifo_empty && wbGnt;

`ifdef WB_BYPASS_EN
    // Only legal when nothing older is queued, so ordering is preserved.
    assign bypass = fifo_empty && wbGnt && in_fire;
`else
    assign bypass = 1'b0;
`endif

    assign push       = in_fire && !bypass;
    assign head_entry = entry_t'(fifo_dout);
    assign out_valid  = pop || bypass;
    assign out_entry  = bypass ? in_entry : head_entry;
    assign out_is_pc  = (out_entry.idx == AW'(PC_IDX));

    // Data outputs are gated by their enables so an idle port shows zero
    // rather than whatever the head slot happens to contain.
    assign wbEn     = out_valid && !out_is_pc;
    assign wbIdx    = wbEn ? out_entry.idx : '0;
    assign wbData   = wbEn ? out_entry.data : '0;
    assign pcWrEn   = out_valid && out_is_pc;
    assign pcWrData = pcWrEn ? out_entry.data : '0;

    assign full  = fifo_full;
    assign empty = fifo_empty;

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (in_entry),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ------------------------------------------------------------------
    // Pending-destination scoreboard. The clear is applied before the set
    // so that a re-allocation in the retiring cycle keeps the bit high.
    // ------------------------------------------------------------------
    always_comb begin
        pend_next = pendMask;
        if (out_valid) begin
            pend_next[out_entry.idx] = 1'b0;
        end
        if (allocEn) begin
            pend_next[allocIdx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendMask <= '0;
        end else begin
            pendMask <= pend_next;
        end
    end

endmodule
